// File: rtl/snitch_narrow_resp_mem_if.sv
// Flattened AXI4 channel bundle between the cluster narrow initiator and its responder.
interface snitch_narrow_resp_mem_if #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4
);
  logic                   aw_valid;
  logic                   aw_ready;
  logic [IdWidth-1:0]     aw_id;
  logic [AddrWidth-1:0]   aw_addr;
  logic [7:0]             aw_len;
  logic                   w_valid;
  logic                   w_ready;
  logic [DataWidth-1:0]   w_data;
  logic [DataWidth/8-1:0] w_strb;
  logic                   w_last;
  logic                   b_valid;
  logic                   b_ready;
  logic [IdWidth-1:0]     b_id;
  logic [1:0]             b_resp;
  logic                   ar_valid;
  logic                   ar_ready;
  logic [IdWidth-1:0]     ar_id;
  logic [AddrWidth-1:0]   ar_addr;
  logic [7:0]             ar_len;
  logic                   r_valid;
  logic                   r_ready;
  logic [IdWidth-1:0]     r_id;
  logic [DataWidth-1:0]   r_data;
  logic [1:0]             r_resp;
  logic                   r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_id, ar_addr, ar_len, r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_id, r_data,
           r_resp, r_last
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, w_valid, w_data, w_strb, w_last, b_ready,
           ar_valid, ar_id, ar_addr, ar_len, r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready, r_valid, r_id, r_data,
           r_resp, r_last
  );
endinterface

// File: rtl/snitch_narrow_resp_mem.sv
// Single-outstanding AXI4 responder backed by a small word-addressed memory. Terminates the
// cluster narrow initiator port so issued transactions complete with real data.
module snitch_narrow_resp_mem #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned MemWords  = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  snitch_narrow_resp_mem_if.slave   axi
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);
  localparam int unsigned IdxW      = $clog2(MemWords);
  localparam int unsigned HiLsb     = OffW + IdxW;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {StIdle, StWrData, StWrResp, StRdData} state_e;

  state_e              state_q, state_d;
  logic [IdWidth-1:0]  id_q, id_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                decerr_q, decerr_d;
  logic                slverr_q, slverr_d;
  logic                prio_rd_q, prio_rd_d;
  logic [DataWidth-1:0] mem_q [MemWords];

  logic aw_oow, ar_oow, last_beat, aw_take, ar_take, mem_we;

  // Byte-offset bits carry no meaning for full-width beats.
  logic unused_addr;
  assign unused_addr = ^{axi.aw_addr[OffW-1:0], axi.ar_addr[OffW-1:0]};

  assign aw_oow    = |axi.aw_addr[AddrWidth-1:HiLsb];
  assign ar_oow    = |axi.ar_addr[AddrWidth-1:HiLsb];
  assign last_beat = (beat_q == len_q);
  // Readies are mutually exclusive whenever both valids are up, so at most one address is taken.
  assign aw_take   = axi.aw_valid && !(axi.ar_valid && prio_rd_q);
  assign ar_take   = axi.ar_valid && !(axi.aw_valid && !prio_rd_q);
  assign mem_we    = !rst_i && (state_q == StWrData) && axi.w_valid && !decerr_q;

  // Next-state, channel outputs and handshake-driven updates; all outputs idle low in reset.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    len_d        = len_q;
    beat_d       = beat_q;
    idx_d        = idx_q;
    decerr_d     = decerr_q;
    slverr_d     = slverr_q;
    prio_rd_d    = prio_rd_q;
    axi.aw_ready = 1'b0;
    axi.ar_ready = 1'b0;
    axi.w_ready  = 1'b0;
    axi.b_valid  = 1'b0;
    axi.b_id     = '0;
    axi.b_resp   = RespOkay;
    axi.r_valid  = 1'b0;
    axi.r_id     = '0;
    axi.r_data   = '0;
    axi.r_resp   = RespOkay;
    axi.r_last   = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        StIdle: begin
          axi.aw_ready = !(axi.ar_valid && prio_rd_q);
          axi.ar_ready = !(axi.aw_valid && !prio_rd_q);
          if (aw_take) begin
            state_d   = StWrData;
            id_d      = axi.aw_id;
            len_d     = axi.aw_len;
            idx_d     = axi.aw_addr[OffW +: IdxW];
            decerr_d  = aw_oow;
            beat_d    = 8'd0;
            slverr_d  = 1'b0;
            prio_rd_d = !prio_rd_q;
          end else if (ar_take) begin
            state_d   = StRdData;
            id_d      = axi.ar_id;
            len_d     = axi.ar_len;
            idx_d     = axi.ar_addr[OffW +: IdxW];
            decerr_d  = ar_oow;
            beat_d    = 8'd0;
            slverr_d  = 1'b0;
            prio_rd_d = !prio_rd_q;
          end
        end
        StWrData: begin
          axi.w_ready = 1'b1;
          if (axi.w_valid) begin
            if (axi.w_last != last_beat) slverr_d = 1'b1;
            idx_d = idx_q + IdxW'(1);
            if (last_beat) state_d = StWrResp;
            else           beat_d  = beat_q + 8'd1;
          end
        end
        StWrResp: begin
          axi.b_valid = 1'b1;
          axi.b_id    = id_q;
          axi.b_resp  = decerr_q ? RespDecErr : (slverr_q ? RespSlvErr : RespOkay);
          if (axi.b_ready) state_d = StIdle;
        end
        StRdData: begin
          axi.r_valid = 1'b1;
          axi.r_id    = id_q;
          axi.r_data  = decerr_q ? '0 : mem_q[idx_q];
          axi.r_resp  = decerr_q ? RespDecErr : RespOkay;
          axi.r_last  = last_beat;
          if (axi.r_ready) begin
            if (last_beat) begin
              state_d = StIdle;
            end else begin
              beat_d = beat_q + 8'd1;
              idx_d  = idx_q + IdxW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      id_q      <= '0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      idx_q     <= '0;
      decerr_q  <= 1'b0;
      slverr_q  <= 1'b0;
      prio_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      decerr_q  <= decerr_d;
      slverr_q  <= slverr_d;
      prio_rd_q <= prio_rd_d;
    end
  end

  // Byte-enabled memory write; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < StrbWidth; i++) begin
        if (axi.w_strb[i]) mem_q[idx_q][8*i +: 8] <= axi.w_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_snitch_narrow_resp_mem.sv
// Scoreboard bench for snitch_narrow_resp_mem: drivers push expected B/R responses, a
// negedge monitor pops and compares on every handshake and checks stall stability.
module tb_snitch_narrow_resp_mem;
  localparam int unsigned AW = 48;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned MW = 256;

  typedef struct packed {logic [IW-1:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct packed {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} r_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snitch_narrow_resp_mem_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bus ();

  snitch_narrow_resp_mem #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MemWords(MW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .axi   (bus)
  );

  b_exp_t b_q[$];
  r_exp_t r_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit toggle   = 1'b0;

  logic [DW-1:0]   wd [4];
  logic [DW/8-1:0] ws [4];
  logic            wl [4];
  logic [DW-1:0]   rd [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response-side readies: constant high, or toggling every cycle to create stalls.
  initial begin
    bus.r_ready = 1'b1;
    bus.b_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle) begin
        bus.r_ready = ~bus.r_ready;
        bus.b_ready = ~bus.b_ready;
      end else begin
        bus.r_ready = 1'b1;
        bus.b_ready = 1'b1;
      end
    end
  end

  // Monitor: compare on handshakes, and require stalled B/R to hold their values.
  bit     b_stall, r_stall;
  b_exp_t b_prev, b_cur, b_e;
  r_exp_t r_prev, r_cur, r_e;
  always @(negedge clk) begin
    b_cur = {bus.b_id, bus.b_resp};
    r_cur = {bus.r_id, bus.r_data, bus.r_resp, bus.r_last};
    if (rst) begin
      b_stall = 1'b0;
      r_stall = 1'b0;
    end else begin
      if (b_stall) check("b_stable", {bus.b_valid, b_cur}, {1'b1, b_prev});
      if (r_stall) check("r_stable", {bus.r_valid, r_cur}, {1'b1, r_prev});
      if (bus.b_valid && bus.b_ready) begin
        if (b_q.size() == 0) check("b_unexpected", bus.b_valid, 1'b0);
        else begin
          b_e = b_q.pop_front();
          check("b_id_resp", b_cur, b_e);
        end
      end
      if (bus.r_valid && bus.r_ready) begin
        if (r_q.size() == 0) check("r_unexpected", bus.r_valid, 1'b0);
        else begin
          r_e = r_q.pop_front();
          check("r_id_data_resp_last", r_cur, r_e);
        end
      end
      b_stall = bus.b_valid && !bus.b_ready;
      r_stall = bus.r_valid && !bus.r_ready;
      b_prev  = b_cur;
      r_prev  = r_cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    bit hs = 1'b0;
    bus.aw_valid = 1'b1; bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      hs = bus.aw_ready;
      tick();
    end
    bus.aw_valid = 1'b0;
    if (!hs) check("aw_timeout", hs, 1'b1);
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    bit hs = 1'b0;
    bus.ar_valid = 1'b1; bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      hs = bus.ar_ready;
      tick();
    end
    bus.ar_valid = 1'b0;
    if (!hs) check("ar_timeout", hs, 1'b1);
  endtask

  task automatic send_w(input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input logic last);
    bit hs = 1'b0;
    bus.w_valid = 1'b1; bus.w_data = data; bus.w_strb = strb; bus.w_last = last;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk);
      hs = bus.w_ready;
      tick();
    end
    bus.w_valid = 1'b0;
    if (!hs) check("w_timeout", hs, 1'b1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 500 && (b_q.size() + r_q.size()) != 0; c++) tick();
    if ((b_q.size() + r_q.size()) != 0) check("drain_timeout", b_q.size() + r_q.size(), 0);
    tick();
  endtask

  // Burst write using wd/ws/wl for beats 0..len.
  task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [1:0] resp);
    b_q.push_back({id, resp});
    send_aw(id, addr, len);
    for (int i = 0; i <= int'(len); i++) send_w(wd[i], ws[i], wl[i]);
    wait_idle();
  endtask

  // Burst read expecting rd[0..len] with the given per-beat response.
  task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [1:0] resp);
    for (int i = 0; i <= int'(len); i++) r_q.push_back({id, rd[i], resp, i == int'(len)});
    send_ar(id, addr, len);
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
    bus.w_valid  = 1'b0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_readies", {bus.aw_ready, bus.ar_ready, bus.w_ready}, 3'b000);
    check("rst_valids", {bus.b_valid, bus.r_valid}, 2'b00);
    check("rst_payload", {bus.b_id, bus.b_resp, bus.r_id, bus.r_data, bus.r_resp, bus.r_last}, '0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("idle_readies", {bus.aw_ready, bus.ar_ready}, 2'b11);
    tick();

    // Simultaneous AW/AR from reset: write wins, read then sees the new data
    b_q.push_back({4'd1, 2'b00});
    r_q.push_back({4'd2, 64'hA5A5_5A5A_0123_4567, 2'b00, 1'b1});
    bus.aw_valid = 1'b1; bus.aw_id = 4'd1; bus.aw_addr = 48'h100; bus.aw_len = 8'd0;
    bus.ar_valid = 1'b1; bus.ar_id = 4'd2; bus.ar_addr = 48'h100; bus.ar_len = 8'd0;
    @(negedge clk);
    check("arb_aw_ready", bus.aw_ready, 1'b1);
    check("arb_ar_ready", bus.ar_ready, 1'b0);
    tick();
    bus.aw_valid = 1'b0;
    send_w(64'hA5A5_5A5A_0123_4567, 8'hFF, 1'b1);
    send_ar(4'd2, 48'h100, 8'd0);
    wait_idle();

    // Single write then read
    wd[0] = 64'hDEAD_BEEF_CAFE_F00D; ws[0] = 8'hFF; wl[0] = 1'b1;
    write_burst(4'd3, 48'h10, 8'd0, 2'b00);
    rd[0] = 64'hDEAD_BEEF_CAFE_F00D;
    read_burst(4'd4, 48'h10, 8'd0, 2'b00);

    // 4-beat burst with back-pressure on B and R
    toggle = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd[i] = 64'(i + 1); ws[i] = 8'hFF; wl[i] = (i == 3); rd[i] = 64'(i + 1);
    end
    write_burst(4'd5, 48'h0, 8'd3, 2'b00);
    read_burst(4'd6, 48'h0, 8'd3, 2'b00);
    toggle = 1'b0;

    // Strobe and wrap across word 255 -> word 0
    wd[0] = '1; ws[0] = 8'hFF; wl[0] = 1'b1;
    write_burst(4'd7, 48'h7F8, 8'd0, 2'b00);
    wd[0] = '0; ws[0] = 8'h0F; wl[0] = 1'b0;
    wd[1] = '0; ws[1] = 8'h0F; wl[1] = 1'b1;
    write_burst(4'd8, 48'h7F8, 8'd1, 2'b00);
    rd[0] = 64'hFFFF_FFFF_0000_0000; rd[1] = 64'h0;
    read_burst(4'd9, 48'h7F8, 8'd1, 2'b00);

    // Out-of-window write: DECERR, word 0 untouched
    wd[0] = 64'h123; ws[0] = 8'hFF; wl[0] = 1'b1;
    write_burst(4'd10, 48'h10_0000, 8'd0, 2'b11);
    rd[0] = 64'h0;
    read_burst(4'd11, 48'h0, 8'd0, 2'b00);

    // Early w_last: SLVERR, data still written
    wd[0] = 64'h77; ws[0] = 8'hFF; wl[0] = 1'b1;
    wd[1] = 64'h88; ws[1] = 8'hFF; wl[1] = 1'b1;
    write_burst(4'd12, 48'h40, 8'd1, 2'b10);
    rd[0] = 64'h77; rd[1] = 64'h88;
    read_burst(4'd13, 48'h40, 8'd1, 2'b00);

    // Out-of-window read: zero data, DECERR each beat
    rd[0] = '0; rd[1] = '0; rd[2] = '0;
    read_burst(4'd14, 48'h100_0000_0000, 8'd2, 2'b11);

    // Reset during beat 2 of a write: no B, beat 1 kept
    send_aw(4'd15, 48'h28, 8'd1);
    send_w(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
    rst = 1'b1;
    bus.w_valid = 1'b1; bus.w_data = 64'h5555; bus.w_strb = 8'hFF; bus.w_last = 1'b1;
    @(negedge clk);
    check("rst_mid_w_ready", bus.w_ready, 1'b0);
    tick();
    rst = 1'b0;
    bus.w_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_readies", {bus.aw_ready, bus.ar_ready, bus.b_valid}, 3'b110);
    tick();
    tick();
    rd[0] = 64'h1111_2222_3333_4444;
    read_burst(4'd1, 48'h28, 8'd0, 2'b00);

    check("queues_empty", b_q.size() + r_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
